// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU operations and datapath select values.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// ALU control decoder: maps the FSM's aluop request and the funct field
// to an ALU operation, flagging functs the datapath does not implement.
module mc_aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       bad_funct
);

  // Unknown functs fall back to add so the instruction still completes.
  always_comb begin
    alucontrol = ALU_ADD;
    bad_funct  = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: begin
            alucontrol = ALU_ADD;
            bad_funct  = 1'b1;
          end
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS datapath with a unified memory; outputs
// decode from the state, with memory strobes qualified by memready.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int STATE_W   = 4,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 memready,
  output logic                 memreq,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 iord,
  output logic                 pcen,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [STATE_W-1:0]   state
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] next_s;
  logic               pcwrite_s;
  logic               branch_s;
  logic               bad_op_s;
  logic               exec_s;
  logic [1:0]         aluop_s;
  logic [2:0]         alu_s;
  logic               bad_funct_s;

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_FETCH;
    else        state_r <= next_s;
  end

  // Next-state and Moore output decode; memory states hold until memready.
  always_comb begin
    next_s    = S_FETCH;
    memreq    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcwrite_s = 1'b0;
    branch_s  = 1'b0;
    iord      = 1'b0;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = SRCB_RT;
    pcsrc     = PCSRC_ALU;
    aluop_s   = ALUOP_ADD;
    bad_op_s  = 1'b0;
    exec_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        memreq    = 1'b1;
        alusrcb   = SRCB_FOUR;
        irwrite   = memready;
        pcwrite_s = memready;
        if (memready) next_s = S_DECODE;
        else          next_s = S_FETCH;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_RTYPE:     next_s = S_EXECUTE;
          OP_BEQ:       next_s = S_BRANCH;
          OP_ADDI:      next_s = S_ADDIEX;
          OP_J:         next_s = S_JUMP;
          default: begin
            next_s   = S_FETCH;
            bad_op_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        if (op == OP_SW) next_s = S_MEMWR;
        else             next_s = S_MEMRD;
      end
      S_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
        if (memready) next_s = S_MEMWB;
        else          next_s = S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        next_s   = S_FETCH;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        iord     = 1'b1;
        memwrite = memready;
        if (memready) next_s = S_FETCH;
        else          next_s = S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop_s = ALUOP_FUNCT;
        exec_s  = 1'b1;
        next_s  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        next_s   = S_FETCH;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop_s  = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        branch_s = 1'b1;
        next_s   = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        next_s  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        next_s   = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = PCSRC_JUMP;
        pcwrite_s = 1'b1;
        next_s    = S_FETCH;
      end
      default: next_s = S_FETCH;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (aluop_s),
    .funct      (funct),
    .alucontrol (alu_s),
    .bad_funct  (bad_funct_s)
  );

  assign alucontrol = ALUCTRL_W'(alu_s);
  assign pcen       = pcwrite_s | (branch_s & zero);
  assign illegal    = bad_op_s | (exec_s & bad_funct_s);
  assign state      = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver applies one directed vector
// per cycle and queues its expectation; a monitor checks each cycle.
module tb_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // strobe order {memreq, memwrite, irwrite, pcen, regwrite, illegal}
  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_REQ  = 6'b100000;
  localparam logic [5:0] S_FETD = 6'b101100;
  localparam logic [5:0] S_WR   = 6'b110000;
  localparam logic [5:0] S_RW   = 6'b000010;
  localparam logic [5:0] S_PC   = 6'b000100;
  localparam logic [5:0] S_ILL  = 6'b000001;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] strb;
    logic [2:0] alu;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, zero, memready;
  logic [5:0] op, funct;
  logic       memreq, memwrite, irwrite, iord, pcen, regwrite, regdst, memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memreq(memreq), .memwrite(memwrite), .irwrite(irwrite), .iord(iord), .pcen(pcen),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // {mask, value} over {iord, regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol}
  function automatic logic [21:0] sel_spec(input logic [3:0] s);
    case (s)
      4'd0:  return {11'b1_0_0_1_11_11_111, 11'b0_0_0_0_01_00_010};
      4'd1:  return {11'b0_0_0_1_11_00_111, 11'b0_0_0_0_11_00_010};
      4'd2:  return {11'b0_0_0_1_11_00_111, 11'b0_0_0_1_10_00_010};
      4'd3:  return {11'b1_0_0_0_00_00_000, 11'b1_0_0_0_00_00_000};
      4'd4:  return {11'b0_1_1_0_00_00_000, 11'b0_0_1_0_00_00_000};
      4'd5:  return {11'b1_0_0_0_00_00_000, 11'b1_0_0_0_00_00_000};
      4'd6:  return {11'b0_0_0_1_11_00_000, 11'b0_0_0_1_00_00_000};
      4'd7:  return {11'b0_1_1_0_00_00_000, 11'b0_1_0_0_00_00_000};
      4'd8:  return {11'b0_0_0_1_11_11_111, 11'b0_0_0_1_00_01_110};
      4'd9:  return {11'b0_0_0_1_11_00_111, 11'b0_0_0_1_10_00_010};
      4'd10: return {11'b0_1_1_0_00_00_000, 11'b0_0_0_0_00_00_000};
      4'd11: return {11'b0_0_0_0_00_11_000, 11'b0_0_0_0_00_10_000};
      default: return 22'd0;
    endcase
  endfunction

  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                      input logic m, input logic [3:0] st, input logic [5:0] sb, input logic [2:0] al);
    @(posedge clk);
    #1;
    reset = r; op = o; funct = f; zero = z; memready = m;
    exp_q.push_back('{st: st, strb: sb, alu: al});
  endtask

  // Monitor: every falling edge, compare the outputs against the queued expectation.
  initial begin
    exp_t        e;
    logic [5:0]  act_strb;
    logic [10:0] act_sel, m_sel, v_sel;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cycle++;
        act_strb = {memreq, memwrite, irwrite, pcen, regwrite, illegal};
        act_sel  = {iord, regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol};
        {m_sel, v_sel} = sel_spec(e.st);
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL state cyc%0d: got %0d want %0d", cycle, state, e.st);
        end
        checks++;
        if (act_strb !== e.strb) begin
          errors++;
          $display("FAIL strobes cyc%0d: got %b want %b", cycle, act_strb, e.strb);
        end
        if (m_sel != 11'd0) begin
          checks++;
          if (((act_sel ^ v_sel) & m_sel) !== 11'd0) begin
            errors++;
            $display("FAIL selects cyc%0d: got %b want %b mask %b", cycle, act_sel, v_sel, m_sel);
          end
        end
        if (e.st == 4'd6) begin
          checks++;
          if (alucontrol !== e.alu) begin
            errors++;
            $display("FAIL alucontrol cyc%0d: got %b want %b", cycle, alucontrol, e.alu);
          end
        end
      end
    end
  end

  // Driver: directed instruction sequences, one vector per clock.
  initial begin
    reset = 1'b0; op = LW; funct = 6'd0; zero = 1'b0; memready = 1'b0;
    step(1'b0, LW, 6'd0, 1'b0, 1'b0, 4'd0, S_REQ,  3'd0);
    // lw interrupted by reset while waiting in MEMRD
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd2, S_IDLE, 3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b0, 4'd3, S_REQ,  3'd0);
    step(1'b0, LW, 6'd0, 1'b0, 1'b0, 4'd0, S_REQ,  3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b0, 4'd0, S_REQ,  3'd0);
    // lw, memready high throughout
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd2, S_IDLE, 3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd3, S_REQ,  3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd4, S_RW,   3'd0);
    // sw with three wait cycles in MEMWR
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, 4'd2, S_IDLE, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b1, SW, 6'd0, 1'b0, 1'b0, 4'd5, S_REQ, 3'd0);
    step(1'b1, SW, 6'd0, 1'b0, 1'b1, 4'd5, S_WR,   3'd0);
    // R-type slt, sub, then an unknown funct
    step(1'b1, RT, 6'b101010, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, RT, 6'b101010, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, RT, 6'b101010, 1'b0, 1'b1, 4'd6, S_IDLE, 3'b111);
    step(1'b1, RT, 6'b101010, 1'b0, 1'b1, 4'd7, S_RW,   3'd0);
    step(1'b1, RT, 6'b100010, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, RT, 6'b100010, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, RT, 6'b100010, 1'b0, 1'b1, 4'd6, S_IDLE, 3'b110);
    step(1'b1, RT, 6'b100010, 1'b0, 1'b1, 4'd7, S_RW,   3'd0);
    step(1'b1, RT, 6'b111111, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, RT, 6'b111111, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, RT, 6'b111111, 1'b0, 1'b1, 4'd6, S_ILL,  3'b010);
    step(1'b1, RT, 6'b111111, 1'b0, 1'b1, 4'd7, S_RW,   3'd0);
    // beq taken (zero high in DECODE must not move pc), then not taken
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, BEQ, 6'd0, 1'b1, 1'b1, 4'd8, S_PC,   3'd0);
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, BEQ, 6'd0, 1'b0, 1'b1, 4'd8, S_IDLE, 3'd0);
    // illegal opcode, then j
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, BAD, 6'd0, 1'b0, 1'b1, 4'd1, S_ILL,  3'd0);
    step(1'b1, JMP, 6'd0, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, JMP, 6'd0, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, JMP, 6'd0, 1'b0, 1'b1, 4'd11, S_PC,  3'd0);
    // addi
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, 4'd9, S_IDLE, 3'd0);
    step(1'b1, ADDI, 6'd0, 1'b0, 1'b1, 4'd10, S_RW,  3'd0);
    // fetch stalled on memready, then completes
    step(1'b1, LW, 6'd0, 1'b0, 1'b0, 4'd0, S_REQ,  3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b0, 4'd0, S_REQ,  3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd0, S_FETD, 3'd0);
    step(1'b1, LW, 6'd0, 1'b0, 1'b1, 4'd1, S_IDLE, 3'd0);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
